// File: rtl/fetch_queue.sv
// fetch_queue: instruction fetch front end with a request/grant/response
// memory port and a small instruction FIFO towards decode.
//
// Capacity DEPTH counts buffered plus in-flight instructions, so the FIFO can
// never overflow. A redirect flushes the FIFO, restarts fetch at the new PC and
// drops the responses still owed for pre-redirect requests.
//
// Ports:
//   clk_i, rst_i                  clock, synchronous active-high reset
//   redirect_i, redirect_pc_i     flush and restart fetch (pc bits [1:0] ignored)
//   imem_req_o, imem_addr_o       fetch request and word-aligned address
//   imem_gnt_i                    request accepted this cycle
//   imem_rvalid_i, imem_rdata_i   in-order response
//   instr_valid_o, instr_o,       queue head toward decode
//   instr_pc_o, instr_ready_i     decode handshake
module fetch_queue #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  output logic        instr_valid_o,
  output logic [31:0] instr_o,
  output logic [31:0] instr_pc_o,
  input  logic        instr_ready_i
);

  localparam int unsigned AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW  = AW + 1;
  localparam logic [CW:0] CAP = (CW+1)'(DEPTH);

  typedef enum logic {RUN, DRAIN} state_t;

  state_t        state, state_nxt;
  logic [31:0]   fetch_pc, resp_pc;
  logic [31:0]   fifo_instr [DEPTH];
  logic [31:0]   fifo_pc    [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] occ, outstanding, discard;
  logic [CW-1:0] outstanding_nxt, discard_nxt;
  logic [CW:0]   in_use;
  logic [31:0]   redirect_pc_al;
  logic          grant, rsp, push, pop;

  assign redirect_pc_al = redirect_pc_i & 32'hFFFF_FFFC;
  assign in_use         = {1'b0, occ} + {1'b0, outstanding};

  assign imem_req_o  = (state == RUN) && !redirect_i && !rst_i && (in_use < CAP);
  assign imem_addr_o = fetch_pc;
  assign grant       = imem_req_o && imem_gnt_i;

  // A response with nothing outstanding is a protocol error and is ignored.
  assign rsp  = imem_rvalid_i && (outstanding != '0);
  assign push = rsp && (discard == '0) && !redirect_i;

  assign instr_valid_o = (occ != '0) && !rst_i;
  assign pop           = instr_valid_o && instr_ready_i && !redirect_i;
  assign instr_o       = fifo_instr[rd_ptr];
  assign instr_pc_o    = fifo_pc[rd_ptr];

  // DRAIN is exactly "stale responses still owed", so the next state follows
  // directly from the next discard count.
  always_comb begin
    outstanding_nxt = outstanding + CW'(grant) - CW'(rsp);
    discard_nxt     = discard;
    if (redirect_i) begin
      discard_nxt = outstanding - CW'(rsp);
    end else if (rsp && (discard != '0)) begin
      discard_nxt = discard - CW'(1);
    end
    state_nxt = (discard_nxt != '0) ? DRAIN : RUN;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= RUN;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      fetch_pc    <= RESET_PC;
      resp_pc     <= RESET_PC;
      occ         <= '0;
      outstanding <= '0;
      discard     <= '0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      fifo_instr  <= '{default: '0};
      fifo_pc     <= '{default: '0};
    end else begin
      outstanding <= outstanding_nxt;
      discard     <= discard_nxt;
      if (redirect_i) begin
        fetch_pc <= redirect_pc_al;
        resp_pc  <= redirect_pc_al;
        occ      <= '0;
        rd_ptr   <= wr_ptr;
      end else begin
        if (grant) begin
          fetch_pc <= fetch_pc + 32'd4;
        end
        if (push) begin
          fifo_instr[wr_ptr] <= imem_rdata_i;
          fifo_pc[wr_ptr]    <= resp_pc;
          wr_ptr             <= wr_ptr + AW'(1);
          resp_pc            <= resp_pc + 32'd4;
        end
        if (pop) begin
          rd_ptr <= rd_ptr + AW'(1);
        end
        occ <= occ + CW'(push) - CW'(pop);
      end
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: in-order memory with configurable latency, a
// queue-based reference model compared every cycle, and directed scenarios
// with hand-computed literal expectations.
module tb_fetch_queue;

  localparam int unsigned DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic        redirect_i = 1'b0;
  logic [31:0] redirect_pc_i = '0;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_gnt_i = 1'b1;
  logic        imem_rvalid_i = 1'b0;
  logic [31:0] imem_rdata_i = '0;
  logic        instr_valid_o;
  logic [31:0] instr_o;
  logic [31:0] instr_pc_o;
  logic        instr_ready_i = 1'b1;

  fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk_i         (clk),
    .rst_i         (rst_i),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .imem_req_o    (imem_req_o),
    .imem_addr_o   (imem_addr_o),
    .imem_gnt_i    (imem_gnt_i),
    .imem_rvalid_i (imem_rvalid_i),
    .imem_rdata_i  (imem_rdata_i),
    .instr_valid_o (instr_valid_o),
    .instr_o       (instr_o),
    .instr_pc_o    (instr_pc_o),
    .instr_ready_i (instr_ready_i)
  );

  always #5 clk = ~clk;

  int unsigned checks = 0;
  int unsigned errors = 0;
  int unsigned cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- memory environment ----------------
  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] due;
  } mreq_t;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } ent_t;

  mreq_t       mem_q[$];
  int unsigned lat = 1;
  logic        spur = 1'b0;
  logic        nxt_rvalid = 1'b0;
  logic [31:0] nxt_rdata = '0;
  int unsigned grant_cnt = 0;
  int unsigned pop_cnt = 0;
  logic [31:0] pop_q[$];

  function automatic logic [31:0] word_at(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h5A5A_0F0F;
  endfunction

  always @(posedge clk) begin
    #1;
    imem_rvalid_i = nxt_rvalid;
    imem_rdata_i  = nxt_rdata;
  end

  // ---------------- reference model ----------------
  ent_t        m_q[$];
  logic [31:0] m_fetch, m_resp;
  int unsigned m_out, m_disc;
  bit          m_live = 0;

  always @(negedge clk) begin : monitor
    bit    exp_req;
    bit    rsp;
    bit    pop_now;
    mreq_t tmp;
    ent_t  ent;

    exp_req = 0;
    // compare DUT outputs against the model state for this cycle
    if (rst_i) begin
      check("req_in_reset", imem_req_o, 0);
      check("valid_in_reset", instr_valid_o, 0);
    end else if (m_live) begin
      exp_req = (m_disc == 0) && !redirect_i && (m_q.size() + m_out < DEPTH);
      check("req", imem_req_o, exp_req);
      check("addr", imem_addr_o, m_fetch);
      check("valid", instr_valid_o, m_q.size() != 0);
      if (m_q.size() != 0) begin
        check("instr", instr_o, m_q[0].instr);
        check("instr_pc", instr_pc_o, m_q[0].pc);
      end
    end

    // memory side: accept grants, schedule in-order responses
    if (rst_i) begin
      mem_q.delete();
    end else begin
      if (imem_req_o && imem_gnt_i) begin
        tmp.addr = imem_addr_o;
        tmp.due  = cyc + lat;
        mem_q.push_back(tmp);
        grant_cnt++;
      end
      if (instr_valid_o && instr_ready_i) begin
        pop_cnt++;
        pop_q.push_back(instr_pc_o);
      end
    end
    nxt_rvalid = 1'b0;
    nxt_rdata  = '0;
    if (mem_q.size() != 0 && mem_q[0].due <= cyc + 1) begin
      nxt_rvalid = 1'b1;
      nxt_rdata  = word_at(mem_q[0].addr);
      void'(mem_q.pop_front());
    end else if (spur) begin
      nxt_rvalid = 1'b1;
      nxt_rdata  = 32'hDEAD_BEEF;
    end

    // advance the model across the coming edge
    if (rst_i) begin
      m_q.delete();
      m_fetch = RESET_PC;
      m_resp  = RESET_PC;
      m_out   = 0;
      m_disc  = 0;
      m_live  = 1;
    end else if (m_live) begin
      rsp = imem_rvalid_i && (m_out != 0);
      if (redirect_i) begin
        m_q.delete();
        m_fetch = redirect_pc_i & 32'hFFFF_FFFC;
        m_resp  = m_fetch;
        if (rsp) m_out--;
        m_disc = m_out;
      end else begin
        pop_now = instr_ready_i && (m_q.size() != 0);
        if (exp_req && imem_gnt_i) begin
          m_fetch += 32'd4;
          m_out++;
        end
        if (rsp) begin
          m_out--;
          if (m_disc != 0) begin
            m_disc--;
          end else begin
            ent.instr = imem_rdata_i;
            ent.pc    = m_resp;
            m_q.push_back(ent);
            m_resp += 32'd4;
          end
        end
        if (pop_now) void'(m_q.pop_front());
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step(input int unsigned n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_valid(input int unsigned budget, output int unsigned when);
    when = 0;
    for (int unsigned i = 0; i < budget; i++) begin
      @(negedge clk);
      if (instr_valid_o) begin
        when = cyc;
        return;
      end
    end
    checks++;
    errors++;
    $display("FAIL wait_valid: got no instr_valid_o expected one within %0d cycles", budget);
  endtask

  task automatic wait_req(input int unsigned budget, output int unsigned when);
    when = 0;
    for (int unsigned i = 0; i < budget; i++) begin
      @(negedge clk);
      if (imem_req_o) begin
        when = cyc;
        return;
      end
    end
    checks++;
    errors++;
    $display("FAIL wait_req: got no imem_req_o expected one within %0d cycles", budget);
  endtask

  task automatic check_pop(input int unsigned idx, input logic [31:0] exp);
    if (idx < pop_q.size()) begin
      check("popped_pc", pop_q[idx], exp);
    end else begin
      checks++;
      errors++;
      $display("FAIL popped_pc: got %0d pops expected entry %0d", pop_q.size(), idx);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish by 200000");
    $fatal(1);
  end

  // ---------------- directed scenarios ----------------
  initial begin
    int unsigned c1, t, t2, p0, g0;

    // reset, then free-running fetch with L=1
    rst_i = 1'b1; imem_gnt_i = 1'b1; instr_ready_i = 1'b1; lat = 1;
    step(2);
    check("instr_after_reset", instr_o, 32'h0);
    check("pc_after_reset", instr_pc_o, 32'h0);
    step(1);
    rst_i = 1'b0;
    c1 = cyc;
    @(negedge clk);
    check("first_req", imem_req_o, 1);
    check("first_addr", imem_addr_o, RESET_PC);
    wait_valid(10, t);
    check("fetch_to_decode_latency", t - c1, 2);
    check("first_pc", instr_pc_o, RESET_PC);
    step(1);
    p0 = pop_cnt;
    step(10);
    check("throughput_10_cycles", pop_cnt - p0, 10);

    // decode stalled: credit limit, then in-order drain; spurious rvalid ignored
    rst_i = 1'b1; instr_ready_i = 1'b0;
    step(1);
    rst_i = 1'b0;
    g0 = grant_cnt;
    step(8);
    check("grants_while_stalled", grant_cnt - g0, 4);
    @(negedge clk);
    check("req_when_full", imem_req_o, 0);
    check("valid_when_full", instr_valid_o, 1);
    check("head_when_full", instr_pc_o, RESET_PC);
    step(1);
    spur = 1'b1;
    step(1);
    spur = 1'b0;
    step(3);
    instr_ready_i = 1'b1;
    pop_q.delete();
    step(6);
    check_pop(0, RESET_PC);
    check_pop(1, RESET_PC + 32'd4);
    check_pop(2, RESET_PC + 32'd8);
    check_pop(3, RESET_PC + 32'd12);
    check_pop(4, RESET_PC + 32'd16);

    // redirect with L=3 and three requests in flight
    rst_i = 1'b1; lat = 3;
    step(1);
    rst_i = 1'b0;
    c1 = cyc;
    step(3);
    redirect_i = 1'b1; redirect_pc_i = 32'h0000_0103;
    step(1);
    redirect_i = 1'b0;
    wait_req(20, t);
    check("drain_first_req_cycle", t - c1, 6);
    check("drain_first_req_addr", imem_addr_o, 32'h0000_0100);
    wait_valid(20, t2);
    check("drain_first_valid_delay", t2 - t, 4);
    check("drain_first_pc", instr_pc_o, 32'h0000_0100);

    // redirect coinciding with rvalid and a pop, L=1 steady state
    rst_i = 1'b1; lat = 1;
    step(1);
    rst_i = 1'b0;
    step(6);
    @(negedge clk);
    check("steady_valid", instr_valid_o, 1);
    step(1);
    redirect_i = 1'b1; redirect_pc_i = 32'h0000_0200;
    step(1);
    redirect_i = 1'b0;
    @(negedge clk);
    check("valid_after_redirect", instr_valid_o, 0);
    check("req_after_redirect", imem_req_o, 1);
    check("addr_after_redirect", imem_addr_o, 32'h0000_0200);

    // address wrap at the top of the 32-bit space
    step(1);
    redirect_i = 1'b1; redirect_pc_i = 32'hFFFF_FFF8;
    step(1);
    redirect_i = 1'b0;
    pop_q.delete();
    @(negedge clk);
    check("wrap_addr0", imem_addr_o, 32'hFFFF_FFF8);
    step(1);
    @(negedge clk);
    check("wrap_addr1", imem_addr_o, 32'hFFFF_FFFC);
    step(1);
    @(negedge clk);
    check("wrap_addr2", imem_addr_o, 32'h0000_0000);
    step(4);
    check_pop(0, 32'hFFFF_FFF8);
    check_pop(1, 32'hFFFF_FFFC);
    check_pop(2, 32'h0000_0000);

    // reset mid-stream with three buffered instructions
    instr_ready_i = 1'b0;
    redirect_i = 1'b1; redirect_pc_i = 32'h0000_0040;
    step(1);
    redirect_i = 1'b0;
    step(3);
    imem_gnt_i = 1'b0;
    step(3);
    @(negedge clk);
    check("occ3_valid", instr_valid_o, 1);
    check("occ3_head", instr_pc_o, 32'h0000_0040);
    check("occ3_req", imem_req_o, 1);
    check("occ3_addr", imem_addr_o, 32'h0000_004C);
    step(1);
    rst_i = 1'b1; imem_gnt_i = 1'b1;
    @(negedge clk);
    check("midreset_req", imem_req_o, 0);
    check("midreset_valid", instr_valid_o, 0);
    step(1);
    rst_i = 1'b0; instr_ready_i = 1'b1;
    check("midreset_instr_cleared", instr_o, 32'h0);
    check("midreset_pc_cleared", instr_pc_o, 32'h0);
    @(negedge clk);
    check("restart_req", imem_req_o, 1);
    check("restart_addr", imem_addr_o, RESET_PC);
    wait_valid(10, t);
    check("restart_first_pc", instr_pc_o, RESET_PC);
    check("restart_first_instr", instr_o, word_at(RESET_PC));

    step(3);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
